// File: rtl/regfile_writeback_if.sv
// Instruction, operand and writeback bundle between the requester/ALU side
// (master) and the register-file writeback unit (slave).
interface regfile_writeback_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  instValid;
  logic                  instReady;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  wbDone;
  logic [ADDR_WIDTH-1:0] wbAddr;
  logic [DATA_WIDTH-1:0] wbData;

  // Requester and ALU side: issues instructions, returns the ALU sum
  modport master (
    output instValid,
    output rs1,
    output rs2,
    output rd,
    output aluResult,
    input  instReady,
    input  readData1,
    input  readData2,
    input  wbDone,
    input  wbAddr,
    input  wbData
  );

  // Register-file side: supplies operands, writes the result back
  modport slave (
    input  instValid,
    input  rs1,
    input  rs2,
    input  rd,
    input  aluResult,
    output instReady,
    output readData1,
    output readData2,
    output wbDone,
    output wbAddr,
    output wbData
  );

endinterface

// File: rtl/regfile_writeback_unit.sv
// Register file with operand launch and delayed ALU-result writeback.
// One instruction in flight at a time: operands are registered on accept,
// the ALU is given ALU_WAIT_CYCLES edges to settle, then aluResult lands in rd.
// A test/boot load port writes registers while idle; a debug port reads them.
module regfile_writeback_unit #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALU_WAIT_CYCLES = 1,
  parameter int ZERO_REG        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_writeback_if.slave    bus,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  output logic [DATA_WIDTH-1:0] dbgData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Pre-edge counter value on the writeback edge; the counter starts at 0
  // on the accept edge, so the writeback edge sees ALU_WAIT_CYCLES-1.
  localparam logic [3:0] LAST_COUNT = 4'(ALU_WAIT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE,
    EXEC
  } stateT;

  stateT                 state;
  logic [3:0]            waitCount;
  logic [ADDR_WIDTH-1:0] rdHold;
  logic [DATA_WIDTH-1:0] regFile [DEPTH];
  logic                  accept;

  // Register 0 is hard-wired to zero when ZERO_REG is set
  function automatic logic isZeroReg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] readReg(input logic [ADDR_WIDTH-1:0] addr);
    return isZeroReg(addr) ? '0 : regFile[addr];
  endfunction

  // Ready only while idle and out of reset; accept is the handshake edge
  always_comb begin
    bus.instReady = (state == IDLE) && !reset;
    accept        = bus.instValid && bus.instReady;
  end

  // Debug read port is a plain combinational view of the register file
  always_comb begin
    dbgData = readReg(dbgAddr);
  end

  // Control FSM, register file, operand and writeback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      waitCount     <= '0;
      rdHold        <= '0;
      bus.readData1 <= '0;
      bus.readData2 <= '0;
      bus.wbDone    <= 1'b0;
      bus.wbAddr    <= '0;
      bus.wbData    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else begin
      bus.wbDone <= 1'b0;
      case (state)
        IDLE: begin
          if (loadEn && !isZeroReg(loadAddr)) begin
            regFile[loadAddr] <= loadData;
          end
          if (accept) begin
            bus.readData1 <= readReg(bus.rs1);
            bus.readData2 <= readReg(bus.rs2);
            rdHold        <= bus.rd;
            waitCount     <= '0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (waitCount == LAST_COUNT) begin
            if (!isZeroReg(rdHold)) begin
              regFile[rdHold] <= bus.aluResult;
            end
            bus.wbAddr <= rdHold;
            bus.wbData <= bus.aluResult;
            bus.wbDone <= 1'b1;
            waitCount  <= '0;
            state      <= IDLE;
          end else begin
            waitCount <= waitCount + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit: three instances cover the
// default timing, a 3-cycle ALU wait, and the hard-wired zero register.
// A simple adder stands in for the ALU on each instance.
module tb_regfile_writeback_unit;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  int   testCount = 0;
  int   failCount = 0;

  regfile_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
  regfile_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();
  regfile_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busC ();

  logic          loadEnA, loadEnB, loadEnC;
  logic [AW-1:0] loadAddrA, loadAddrB, loadAddrC;
  logic [DW-1:0] loadDataA, loadDataB, loadDataC;
  logic [AW-1:0] dbgAddrA, dbgAddrB, dbgAddrC;
  logic [DW-1:0] dbgDataA, dbgDataB, dbgDataC;

  // 20 ns clock
  always #10 clk = ~clk;

  // Stand-in ALU: 8-bit add, carry dropped
  assign busA.aluResult = busA.readData1 + busA.readData2;
  assign busB.aluResult = busB.readData1 + busB.readData2;
  assign busC.aluResult = busC.readData1 + busC.readData2;

  regfile_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_WAIT_CYCLES(1), .ZERO_REG(0)) dutA (
    .clk(clk), .reset(reset), .bus(busA),
    .loadEn(loadEnA), .loadAddr(loadAddrA), .loadData(loadDataA),
    .dbgAddr(dbgAddrA), .dbgData(dbgDataA)
  );

  regfile_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_WAIT_CYCLES(3), .ZERO_REG(0)) dutB (
    .clk(clk), .reset(reset), .bus(busB),
    .loadEn(loadEnB), .loadAddr(loadAddrB), .loadData(loadDataB),
    .dbgAddr(dbgAddrB), .dbgData(dbgDataB)
  );

  regfile_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_WAIT_CYCLES(1), .ZERO_REG(1)) dutC (
    .clk(clk), .reset(reset), .bus(busC),
    .loadEn(loadEnC), .loadAddr(loadAddrC), .loadData(loadDataC),
    .dbgAddr(dbgAddrC), .dbgData(dbgDataC)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an instruction to instance A (takes effect on the next edge)
  task automatic applyStimulus(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d);
    busA.instValid = 1'b1;
    busA.rs1       = s1;
    busA.rs2       = s2;
    busA.rd        = d;
  endtask

  task automatic loadRegA(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    loadEnA   = 1'b1;
    loadAddrA = addr;
    loadDataA = data;
    tick();
    loadEnA   = 1'b0;
  endtask

  task automatic checkRegA(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    dbgAddrA = addr;
    #1;
    checkOutput(tag, 32'(dbgDataA), 32'(expected));
  endtask

  task automatic checkRegB(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    dbgAddrB = addr;
    #1;
    checkOutput(tag, 32'(dbgDataB), 32'(expected));
  endtask

  task automatic checkRegC(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
    dbgAddrC = addr;
    #1;
    checkOutput(tag, 32'(dbgDataC), 32'(expected));
  endtask

  initial begin
    reset = 1'b1;
    busA.instValid = 1'b0; busA.rs1 = '0; busA.rs2 = '0; busA.rd = '0;
    busB.instValid = 1'b0; busB.rs1 = '0; busB.rs2 = '0; busB.rd = '0;
    busC.instValid = 1'b0; busC.rs1 = '0; busC.rs2 = '0; busC.rd = '0;
    loadEnA = 1'b0; loadAddrA = '0; loadDataA = '0; dbgAddrA = '0;
    loadEnB = 1'b0; loadAddrB = '0; loadDataB = '0; dbgAddrB = '0;
    loadEnC = 1'b0; loadAddrC = '0; loadDataC = '0; dbgAddrC = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_instReady", 32'(busA.instReady), 32'h0);
    checkOutput("rst_readData1", 32'(busA.readData1), 32'h0);
    checkOutput("rst_readData2", 32'(busA.readData2), 32'h0);
    checkOutput("rst_wbDone", 32'(busA.wbDone), 32'h0);
    checkOutput("rst_wbData", 32'(busA.wbData), 32'h0);
    checkRegA("rst_r0", 3'd0, 8'h00);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(busA.instReady), 32'h1);

    // Basic add: r3 = r1 + r2
    loadRegA(3'd1, 8'h05);
    loadRegA(3'd2, 8'h07);
    applyStimulus(3'd1, 3'd2, 3'd3);
    tick();
    busA.instValid = 1'b0;
    checkOutput("add_readData1", 32'(busA.readData1), 32'h05);
    checkOutput("add_readData2", 32'(busA.readData2), 32'h07);
    checkOutput("add_busy", 32'(busA.instReady), 32'h0);
    checkOutput("add_noDoneYet", 32'(busA.wbDone), 32'h0);
    tick();
    checkOutput("add_wbDone", 32'(busA.wbDone), 32'h1);
    checkOutput("add_wbAddr", 32'(busA.wbAddr), 32'h3);
    checkOutput("add_wbData", 32'(busA.wbData), 32'h0C);
    checkOutput("add_readyAgain", 32'(busA.instReady), 32'h1);
    checkRegA("add_r3", 3'd3, 8'h0C);
    tick();
    checkOutput("add_wbDonePulse", 32'(busA.wbDone), 32'h0);

    // 8-bit wrap, then a dependent instruction held during EXEC
    loadRegA(3'd1, 8'hF0);
    loadRegA(3'd2, 8'h20);
    applyStimulus(3'd1, 3'd2, 3'd4);
    tick();
    applyStimulus(3'd4, 3'd4, 3'd5);
    tick();
    checkOutput("wrap_wbData", 32'(busA.wbData), 32'h10);
    checkOutput("wrap_wbAddr", 32'(busA.wbAddr), 32'h4);
    checkOutput("dep_readyHeld", 32'(busA.instReady), 32'h1);
    checkOutput("dep_notAcceptedInExec", 32'(busA.readData1), 32'hF0);
    tick();
    busA.instValid = 1'b0;
    checkOutput("dep_readData1", 32'(busA.readData1), 32'h10);
    checkOutput("dep_readData2", 32'(busA.readData2), 32'h10);
    checkOutput("dep_busy", 32'(busA.instReady), 32'h0);
    tick();
    checkOutput("dep_wbDone", 32'(busA.wbDone), 32'h1);
    checkRegA("dep_r5", 3'd5, 8'h20);

    // Load during EXEC is dropped
    applyStimulus(3'd1, 3'd1, 3'd7);
    tick();
    busA.instValid = 1'b0;
    loadEnA = 1'b1; loadAddrA = 3'd6; loadDataA = 8'hAA;
    tick();
    loadEnA = 1'b0;
    checkRegA("execLoad_r6", 3'd6, 8'h00);
    checkRegA("execLoad_r7", 3'd7, 8'hE0);

    // Load and accept on the same edge: operand sees the old r2
    loadEnA = 1'b1; loadAddrA = 3'd2; loadDataA = 8'h33;
    applyStimulus(3'd1, 3'd2, 3'd6);
    tick();
    loadEnA = 1'b0;
    busA.instValid = 1'b0;
    checkOutput("sameEdge_readData2", 32'(busA.readData2), 32'h20);
    checkRegA("sameEdge_r2", 3'd2, 8'h33);
    tick();
    checkOutput("sameEdge_wbDone", 32'(busA.wbDone), 32'h1);
    checkOutput("stable_readData2", 32'(busA.readData2), 32'h20);
    checkRegA("sameEdge_r6", 3'd6, 8'h10);

    // Reset one cycle after accept aborts the writeback
    applyStimulus(3'd1, 3'd2, 3'd3);
    tick();
    busA.instValid = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("abort_wbDone", 32'(busA.wbDone), 32'h0);
    checkOutput("abort_readyInReset", 32'(busA.instReady), 32'h0);
    checkOutput("abort_readData1", 32'(busA.readData1), 32'h0);
    checkRegA("abort_r3", 3'd3, 8'h00);
    reset = 1'b0;
    #1;
    checkOutput("abort_readyAfter", 32'(busA.instReady), 32'h1);
    tick();
    checkOutput("abort_wbDoneLater", 32'(busA.wbDone), 32'h0);
    checkRegA("abort_r3Later", 3'd3, 8'h00);

    // ALU_WAIT_CYCLES = 3: busy for exactly 3 cycles, EXEC requests ignored
    loadEnB = 1'b1; loadAddrB = 3'd1; loadDataB = 8'h03;
    tick();
    loadAddrB = 3'd2; loadDataB = 8'h04;
    tick();
    loadEnB = 1'b0;
    busB.instValid = 1'b1; busB.rs1 = 3'd1; busB.rs2 = 3'd2; busB.rd = 3'd5;
    tick();
    busB.rs1 = 3'd2; busB.rs2 = 3'd2; busB.rd = 3'd6;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wait3_busy%0d", i), 32'(busB.instReady), 32'h0);
      checkOutput($sformatf("wait3_operand%0d", i), 32'(busB.readData1), 32'h03);
      checkOutput($sformatf("wait3_noDone%0d", i), 32'(busB.wbDone), 32'h0);
      tick();
    end
    busB.instValid = 1'b0;
    checkOutput("wait3_wbDone", 32'(busB.wbDone), 32'h1);
    checkOutput("wait3_wbAddr", 32'(busB.wbAddr), 32'h5);
    checkOutput("wait3_ready", 32'(busB.instReady), 32'h1);
    checkRegB("wait3_r5", 3'd5, 8'h07);
    tick();
    checkOutput("wait3_wbDonePulse", 32'(busB.wbDone), 32'h0);
    checkRegB("wait3_r6", 3'd6, 8'h00);

    // ZERO_REG = 1: r0 ignores loads and writebacks, reads as 0
    loadEnC = 1'b1; loadAddrC = 3'd0; loadDataC = 8'h55;
    tick();
    loadAddrC = 3'd1; loadDataC = 8'h11;
    checkRegC("zero_r0Load", 3'd0, 8'h00);
    tick();
    loadEnC = 1'b0;
    busC.instValid = 1'b1; busC.rs1 = 3'd0; busC.rs2 = 3'd1; busC.rd = 3'd0;
    tick();
    busC.instValid = 1'b0;
    checkOutput("zero_readData1", 32'(busC.readData1), 32'h00);
    checkOutput("zero_readData2", 32'(busC.readData2), 32'h11);
    checkRegC("zero_r0Exec", 3'd0, 8'h00);
    tick();
    checkOutput("zero_wbDone", 32'(busC.wbDone), 32'h1);
    checkOutput("zero_wbData", 32'(busC.wbData), 32'h11);
    checkOutput("zero_wbAddr", 32'(busC.wbAddr), 32'h0);
    checkRegC("zero_r0After", 3'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
- Operand-supply and result-writeback end of the ALU datapath.
- Holds an 8-entry x 8-bit register file and accepts one instruction at a time (rs1, rs2, rd).
- Drives registered readData1/readData2 to ALU_Unit, waits a fixed number of cycles for the ALU to settle, then writes aluResult back into rd.
- Also provides a test/boot load port and a debug read port.

Parameters:
- DATA_WIDTH, 8: register and operand width.
- ADDR_WIDTH, 3: register address width; depth = 2**ADDR_WIDTH.
- ALU_WAIT_CYCLES, 1: clock edges from operand launch to aluResult sample. Legal range is 1..15.
- ZERO_REG, 0: when 1, register 0 reads as 0 and writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instValid  in  1  instruction request
- instReady  out  1  unit idle, can accept an instruction
- rs1  in  ADDR_WIDTH  source register 1
- rs2  in  ADDR_WIDTH  source register 2
- rd  in  ADDR_WIDTH  destination register
- readData1  out  DATA_WIDTH  operand A to ALU (registered)
- readData2  out  DATA_WIDTH  operand B to ALU (registered)
- aluResult  in  DATA_WIDTH  ALU sum
- wbDone  out  1  one-cycle pulse after writeback
- wbAddr  out  ADDR_WIDTH  rd of the last writeback (registered)
- wbData  out  DATA_WIDTH  value written at the last writeback (registered)
- loadEn  in  1  direct register write request
- loadAddr  in  ADDR_WIDTH  load target
- loadData  in  DATA_WIDTH  load value
- dbgAddr  in  ADDR_WIDTH  debug read address
- dbgData  out  DATA_WIDTH  combinational read of reg[dbgAddr]

Behaviour:
- Reset:
  - All registers are 0.
  - readData1, readData2, wbAddr, wbData are 0; wbDone is 0.
  - State is IDLE, wait counter is 0.
  - instReady is 0 while reset is high.
- States: IDLE, EXEC.
  - instReady = (state == IDLE) && !reset.
- IDLE -> EXEC on the edge where instValid && instReady (edge E0). At E0:
  - rs1, rs2, rd are captured.
  - readData1 <= reg[rs1] and readData2 <= reg[rs2], using pre-edge register contents.
  - Counter is cleared.
- EXEC:
  - Counter increments each edge.
  - At edge E0 + ALU_WAIT_CYCLES: reg[rd] <= aluResult, wbAddr <= rd, wbData <= aluResult, wbDone <= 1, state -> IDLE.
- wbDone:
  - High for exactly the one cycle following the writeback edge, otherwise 0.
- Back-to-back timing:
  - Earliest next accept is edge E0 + ALU_WAIT_CYCLES + 1.
  - A dependent instruction (rs == previous rd) therefore always reads the written-back value; no forwarding is needed.
- Operand stability:
  - readData1/readData2 hold their values from E0 until the next accept edge.
  - They are not changed by loads, writebacks, or the EXEC state.
- Load port:
  - Honoured only in IDLE.
  - reg[loadAddr] <= loadData.
  - loadEn in EXEC is ignored; the write is dropped, not queued.
- Load and accept on the same edge:
  - Both take effect.
  - Operands read the pre-load value.
  - The load is visible to later instructions.
- ZERO_REG = 1:
  - Loads or writebacks to register 0 are dropped.
  - Reads of register 0 (operands and dbgData) return 0.
  - wbDone still pulses; wbData shows the dropped aluResult value.
- Arithmetic: the unit does none. aluResult is stored verbatim and is DATA_WIDTH wide, so ALU carry-out is already lost.
- Reset mid-EXEC:
  - Operation is aborted; no writeback, wbDone stays 0.
  - All registers clear.
  - instReady goes to 1 on the first cycle with reset low.
- instValid while instReady is 0 is ignored; the requester must hold it until accepted.

Test Plan:
- Reset, then load r1 = 0x05 and r2 = 0x07. Issue rs1=1, rs2=2, rd=3 with ALU connected -> readData1 = 0x05 and readData2 = 0x07 after E0; at E0+1, r3 = 0x0C, wbDone pulses for 1 cycle, wbAddr = 3, wbData = 0x0C.
- r1 = 0xF0, r2 = 0x20, rd = 4 -> r4 = 0x10 (8-bit wrap). Then hold instValid with rs1=4, rs2=4, rd=5 -> accepted at the first IDLE edge; r5 = 0x20 (dependent instruction reads the written-back value).
- ALU_WAIT_CYCLES = 3: instReady low for exactly 3 cycles after accept; instValid asserted during EXEC is not accepted; writeback occurs at E0+3.
- loadEn during EXEC to r6 = 0xAA -> r6 unchanged (dbgData(6) = 0x00). loadEn r2 = 0x33 on the same edge as accepting rs2=2 -> readData2 shows the old r2; dbgData(2) = 0x33 afterwards.
- Reset asserted one cycle after accept -> no writeback, rd register = 0, wbDone never asserts, instReady = 1 the cycle after reset deasserts.
- ZERO_REG = 1: load r0 = 0x55, then run an instruction with rd = 0 -> dbgData(0) = 0x00 throughout, wbDone still pulses.
